// File: rtl/shift_exec_unit.sv
// shift_exec_unit: registered-operand 16-bit shifter feeding a 2-entry result queue.
// Define SHIFT_ROTATE_EN to build ROL/ROR; otherwise ops 10/11 pass data through with err set.
module shift_exec_unit #(
  parameter int OPERAND_WIDTH = 16,
  parameter int SHAMT_WIDTH   = 4,
  parameter int TAG_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [OPERAND_WIDTH-1:0] in_data,
  input  logic [SHAMT_WIDTH-1:0]   in_shamt,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_zero,
  output logic                     out_err
);
  logic                     r_s1_valid;
  logic [1:0]               r_s1_op;
  logic [OPERAND_WIDTH-1:0] r_s1_data;
  logic [SHAMT_WIDTH-1:0]   r_s1_shamt;
  logic [TAG_WIDTH-1:0]     r_s1_tag;
  logic [OPERAND_WIDTH-1:0] r_q_data [2];
  logic [TAG_WIDTH-1:0]     r_q_tag  [2];
  logic [1:0]               r_q_zero, r_q_err;
  logic                     r_wr_ptr, r_rd_ptr;
  logic [1:0]               r_count;
  logic                     w_pop, w_adv, w_acc, w_err;
  logic [OPERAND_WIDTH-1:0] w_res;
  assign w_pop     = out_valid && out_ready;
  assign w_adv     = r_s1_valid && (r_count < 2'd2 || w_pop);
  assign in_ready  = !r_s1_valid || w_adv;
  assign w_acc     = in_valid && in_ready && !flush;
  assign out_valid = r_count != 2'd0;
  assign out_data  = r_q_data[r_rd_ptr];
  assign out_tag   = r_q_tag[r_rd_ptr];
  assign out_zero  = r_q_zero[r_rd_ptr];
  assign out_err   = r_q_err[r_rd_ptr];
`ifdef SHIFT_ROTATE_EN
  logic [SHAMT_WIDTH:0]     w_rshamt;
  logic [OPERAND_WIDTH-1:0] w_rol, w_ror;
  // complementary amount reaches OPERAND_WIDTH at shamt 0, which shifts everything out
  assign w_rshamt = (SHAMT_WIDTH+1)'(OPERAND_WIDTH) - {1'b0, r_s1_shamt};
  assign w_rol    = (r_s1_data << r_s1_shamt) | (r_s1_data >> w_rshamt);
  assign w_ror    = (r_s1_data >> r_s1_shamt) | (r_s1_data << w_rshamt);
  always_comb begin
    w_res = r_s1_op == 2'b00 ? r_s1_data << r_s1_shamt :
            r_s1_op == 2'b01 ? r_s1_data >> r_s1_shamt :
            r_s1_op == 2'b10 ? w_rol : w_ror;
    w_err = 1'b0;
  end
`else
  always_comb begin
    w_res = r_s1_op[1] ? r_s1_data :
            r_s1_op[0] ? r_s1_data >> r_s1_shamt : r_s1_data << r_s1_shamt;
    w_err = r_s1_op[1];
  end
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_data  <= '0;
      r_s1_shamt <= '0;
      r_s1_tag   <= '0;
    end else begin
      if (w_acc) begin
        r_s1_op    <= in_op;
        r_s1_data  <= in_data;
        r_s1_shamt <= in_shamt;
        r_s1_tag   <= in_tag;
      end
      r_s1_valid <= flush ? 1'b0 : w_acc ? 1'b1 : w_adv ? 1'b0 : r_s1_valid;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_tag[0]  <= '0;
      r_q_tag[1]  <= '0;
      r_q_zero    <= '0;
      r_q_err     <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_adv) begin
        r_q_data[r_wr_ptr] <= w_res;
        r_q_tag[r_wr_ptr]  <= r_s1_tag;
        r_q_zero[r_wr_ptr] <= w_res == '0;
        r_q_err[r_wr_ptr]  <= w_err;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_adv) - 2'(w_pop);
    end
  end
endmodule

// File: tb/tb_shift_exec_unit.sv
// tb_shift_exec_unit: randomized and directed checks against an in-order in-flight request model.
module tb_shift_exec_unit;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]  in_op = '0;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  logic [2:0]  in_tag = '0;
  logic        in_ready, out_valid, out_zero, out_err;
  logic [15:0] out_data;
  logic [2:0]  out_tag;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] d; logic [2:0] t; logic z; logic e; bit inq;} item_t;
  item_t mq[$];
  shift_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_zero(out_zero), .out_err(out_err)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d, input logic [3:0] s);
    int unsigned x, r;
    x = d;
    if (op == 2'b00) r = x << s;
    else if (op == 2'b01) r = x >> s;
`ifdef SHIFT_ROTATE_EN
    else if (op == 2'b10) r = (x << s) | (x >> (16 - s));
    else r = (x >> s) | (x << (16 - s));
`else
    else r = x;
`endif
    return r[15:0];
  endfunction
  function automatic logic ref_err(input logic [1:0] op);
`ifdef SHIFT_ROTATE_EN
    return 1'b0;
`else
    return op[1];
`endif
  endfunction
  // one clock cycle: drive, compare against model, advance model at the edge
  task automatic cyc(input logic v, input logic [1:0] op, input logic [15:0] d, input logic [3:0] s,
                     input logic [2:0] t, input logic ordy, input logic fl,
                     output bit acc, output bit popd, output logic [15:0] pd, output logic [2:0] pt,
                     output logic pz, output logic pe);
    bit ev, pop, er;
    int nq;
    item_t it;
    in_valid = v; in_op = op; in_data = d; in_shamt = s; in_tag = t; out_ready = ordy; flush = fl;
    #1;
    ev = mq.size() > 0 && mq[0].inq;
    pop = ev && ordy;
    er = mq.size() < 3 || pop;
    checks++;
    if (out_valid !== ev) begin errors++; $display("FAIL out_valid got %b exp %b at %0t", out_valid, ev, $time); end
    checks++;
    if (in_ready !== er) begin errors++; $display("FAIL in_ready got %b exp %b at %0t", in_ready, er, $time); end
    if (ev) begin
      checks++;
      if ({out_data, out_tag, out_zero, out_err} !== {mq[0].d, mq[0].t, mq[0].z, mq[0].e}) begin
        errors++;
        $display("FAIL head got d=%h t=%0d z=%b e=%b exp d=%h t=%0d z=%b e=%b at %0t",
                 out_data, out_tag, out_zero, out_err, mq[0].d, mq[0].t, mq[0].z, mq[0].e, $time);
      end
    end
    acc = v && er && !fl;
    popd = pop; pd = out_data; pt = out_tag; pz = out_zero; pe = out_err;
    nq = 0;
    foreach (mq[i]) if (mq[i].inq) nq++;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (mq.size() > 0 && !mq[mq.size()-1].inq && (nq < 2 || pop)) mq[mq.size()-1].inq = 1;
    if (acc) begin
      it.d = ref_shift(op, d, s); it.t = t; it.z = it.d == 16'h0; it.e = ref_err(op); it.inq = 0;
      mq.push_back(it);
    end
    if (fl) mq.delete();
    #1;
  endtask
  task automatic idle(input int n, input logic ordy);
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, ordy, 0, a, p, d, t, z, e);
  endtask
  task automatic drain();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    for (int i = 0; i < 20 && mq.size() > 0; i++) cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
    checks++;
    if (mq.size() != 0) begin errors++; $display("FAIL drain left %0d items exp 0", mq.size()); end
  endtask
  task automatic check_reset_outputs(input string name);
    checks++;
    if ({out_valid, out_data, out_tag, out_zero, out_err, in_ready} !== {1'b0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s got v=%b d=%h t=%0d z=%b e=%b rdy=%b exp 0/0000/0/0/0/1",
               name, out_valid, out_data, out_tag, out_zero, out_err, in_ready);
    end
  endtask
  task automatic test_reset();
    #3;
    check_reset_outputs("reset");
    #4 rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_single();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    cyc(1, 2'b00, 16'h0001, 4'd15, 3'd5, 1, 0, a, p, d, t, z, e);
    cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
    cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
    checks++;
    if ({p, d, t, z} !== {1'b1, 16'h8000, 3'd5, 1'b0}) begin
      errors++;
      $display("FAIL single got v=%b d=%h t=%0d z=%b exp 1/8000/5/0", p, d, t, z);
    end
    drain();
  endtask
  task automatic test_back_to_back();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    logic [15:0] gd[$]; logic gz[$]; int gc[$];
    for (int c = 0; c < 6; c++) begin
      if (c == 0) cyc(1, 2'b01, 16'h8000, 4'd15, 3'd1, 1, 0, a, p, d, t, z, e);
      else if (c == 1) cyc(1, 2'b01, 16'h0001, 4'd1, 3'd2, 1, 0, a, p, d, t, z, e);
      else if (c == 2) cyc(1, 2'b00, 16'hFFFF, 4'd0, 3'd3, 1, 0, a, p, d, t, z, e);
      else cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
      if (p) begin gd.push_back(d); gz.push_back(z); gc.push_back(c); end
    end
    checks++;
    if (gd.size() != 3 || gc[0] != 2 || gc[2] != 4) begin
      errors++; $display("FAIL b2b pop count %0d exp 3 on cycles 2..4", gd.size());
    end else begin
      checks++;
      if ({gd[0], gd[1], gd[2], gz[0], gz[1], gz[2]} !== {16'h0001, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL b2b got %h %h %h z=%b%b%b exp 0001 0000 ffff z=010", gd[0], gd[1], gd[2], gz[0], gz[1], gz[2]);
      end
    end
    drain();
  endtask
  task automatic test_backpressure();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    int n = 0; logic [2:0] tags[$];
    for (int c = 0; c < 6; c++) begin
      cyc(1, 2'b00, 16'h00F0, 3'(n), 3'(n), 0, 0, a, p, d, t, z, e);
      if (a) n++;
    end
    checks++;
    if (n != 3 || in_ready !== 1'b0) begin errors++; $display("FAIL backpressure accepts %0d rdy %b exp 3 0", n, in_ready); end
    for (int c = 0; c < 10 && n < 4; c++) begin
      cyc(1, 2'b00, 16'h00F0, 3'(n), 3'(n), 1, 0, a, p, d, t, z, e);
      if (p) tags.push_back(t);
      if (a) n++;
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL 4th accept got %0d exp 4", n); end
    for (int c = 0; c < 10; c++) begin
      cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
      if (p) tags.push_back(t);
    end
    checks++;
    if (tags.size() != 4 || tags[0] != 0 || tags[1] != 1 || tags[2] != 2 || tags[3] != 3) begin
      errors++; $display("FAIL backpressure order got %0d tags exp 0,1,2,3", tags.size());
    end
  endtask
  task automatic test_wrap();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    int n = 0; logic [2:0] tags[$];
    for (int c = 0; c < 40 && (n < 6 || mq.size() > 0); c++) begin
      cyc(n < 6, 2'b01, 16'hA5A5, 3'(c), 3'(n), 1'(c % 2), 0, a, p, d, t, z, e);
      if (a) n++;
      if (p) tags.push_back(t);
    end
    checks++;
    if (tags.size() != 6) begin
      errors++; $display("FAIL wrap got %0d results exp 6", tags.size());
    end else
      foreach (tags[i]) begin
        checks++;
        if (tags[i] !== 3'(i)) begin errors++; $display("FAIL wrap tag[%0d] got %0d exp %0d", i, tags[i], i); end
      end
  endtask
  task automatic test_flush();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    int n = 0, seen = 0;
    for (int c = 0; c < 6 && n < 3; c++) begin
      cyc(1, 2'b00, 16'h1234, 4'd2, 3'(n + 1), 0, 0, a, p, d, t, z, e);
      if (a) n++;
    end
    cyc(1, 2'b00, 16'h7777, 4'd1, 3'd7, 0, 1, a, p, d, t, z, e);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
      if (p) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush leaked %0d results exp 0", seen); end
  endtask
  task automatic test_rotate();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    logic [15:0] gd = 16'h0; logic ge = 1'b0; bit got = 0;
    cyc(1, 2'b10, 16'h8001, 4'd1, 3'd4, 1, 0, a, p, d, t, z, e);
    for (int c = 0; c < 4; c++) begin
      cyc(0, 2'b00, 16'h0, 4'h0, 3'h0, 1, 0, a, p, d, t, z, e);
      if (p) begin gd = d; ge = e; got = 1; end
    end
    checks++;
`ifdef SHIFT_ROTATE_EN
    if (!got || gd !== 16'h0003 || ge !== 1'b0) begin errors++; $display("FAIL rotate got %h err %b exp 0003 0", gd, ge); end
`else
    if (!got || gd !== 16'h8001 || ge !== 1'b1) begin errors++; $display("FAIL rotate got %h err %b exp 8001 1", gd, ge); end
`endif
  endtask
  task automatic test_random();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    for (int c = 0; c < 400; c++)
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom_range(0, 7) == 0 ? 0 : $urandom),
          4'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
          a, p, d, t, z, e);
    drain();
  endtask
  task automatic test_async_reset();
    bit a, p; logic [15:0] d; logic [2:0] t; logic z, e;
    for (int c = 0; c < 4; c++) cyc(1, 2'b00, 16'h0F0F, 4'd3, 3'(c + 1), 0, 0, a, p, d, t, z, e);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    mq.delete();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    idle(3, 1);
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_flush();
    test_rotate();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_exec_unit.md
# shift_exec_unit

Pipelined execute-stage shift unit for the 16-bit datapath. It accepts one shift request per cycle over a valid/ready handshake and registers the operands. It computes the result with the team's combinational shifter blocks (sll, srl, rotate) and buffers results in a 2-entry output queue. Downstream back-pressure (memory-stage stall) therefore never corrupts an in-flight result.

## Interface
Parameters:
- OPERAND_WIDTH, 16, data width; only 16 is supported.
- SHAMT_WIDTH, 4, shift-amount width; must equal log2(OPERAND_WIDTH).
- TAG_WIDTH, 3, opaque destination-register tag carried with each request.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all in-flight requests.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  2  00 SLL, 01 SRL, 10 ROL, 11 ROR.
- in_data  input  OPERAND_WIDTH  operand.
- in_shamt  input  SHAMT_WIDTH  shift amount, 0–15.
- in_tag  input  TAG_WIDTH  request tag.
- out_valid  output  1  queue head holds a result.
- out_ready  input  1  downstream consumes the head this cycle.
- out_data  output  OPERAND_WIDTH  result at queue head.
- out_tag  output  TAG_WIDTH  tag of head.
- out_zero  output  1  out_data == 0.
- out_err  output  1  head request had an unsupported op.

## Operation
- Stage S1: operand register with s1_valid. Load on accept (in_valid && in_ready).
- Combinational shift of S1 contents:
  - SLL: zero-fill from the right.
  - SRL: zero-fill from the left.
  - ROL/ROR: rotate.
  - shamt 0: passes the operand unchanged for all ops.
- Output queue: 2 entries. Each entry holds {data, tag, zero, err}. Circular read and write pointers wrap 1→0, plus a 2-bit count.
- S1 advance: s1_valid && (count < 2 || pop). Pop = out_valid && out_ready.
- in_ready = !s1_valid || s1_advance. This is combinational from out_ready and state; there is no combinational path from in_valid.
- Simultaneous push and pop at count 2: legal; count stays 2.
- Simultaneous push and pop at count 1: count stays 1; the head advances.
- Pop at count 0: impossible, since out_valid = 0.
- flush:
  - Clears s1_valid, count and both pointers at the next edge.
  - A request offered in the flush cycle is dropped even if in_ready = 1.
  - A pop in the flush cycle still completes.
- out_zero is computed at S1 and stored in the queue, not recomputed at the output.
- Reset values:
  - s1_valid 0, count 0, pointers 0.
  - out_valid 0, out_data 0, out_tag 0, out_zero 0, out_err 0.
  - in_ready 1.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing
- Latency: a request accepted at edge N is in S1 after N, is written to the queue at edge N+1, and is visible on out_* after N+1. That is 2 cycles when the queue is not full.
- Throughput: 1 result per cycle with out_ready held high.
- Capacity: at most 3 requests in flight (S1 plus 2 queue entries). With out_ready low, in_ready drops after the third accept.
- The out_* signals come directly from queue registers or the read mux; they have no combinational dependency on in_*.
- out_* must hold stable while out_valid && !out_ready.

## Configuration
- SHIFT_ROTATE_EN defined: ops 10 and 11 perform ROL and ROR; out_err is always 0.
- SHIFT_ROTATE_EN undefined:
  - Rotate logic is not compiled.
  - Ops 10 and 11 return in_data unchanged with err = 1 and a normal tag.
  - Handshake and timing are unchanged.

## Test plan
- Reset, then single SLL: in_data 0x0001, shamt 15, tag 5 → out_valid 2 cycles later, out_data 0x8000, out_tag 5, out_zero 0.
- Back-to-back with out_ready = 1:
  - Stimulus: SRL 0x8000 by 15, then SRL 0x0001 by 1, then SLL 0xFFFF by 0.
  - Response: out_data 0x0001, 0x0000 (out_zero 1), 0xFFFF on consecutive cycles.
- Back-pressure:
  - Stimulus: out_ready = 0, offer 4 requests.
  - Response: in_ready deasserts after the third accept. Releasing out_ready drains the results in order with tags intact, and the 4th request is then accepted.
- Push and pop together at count 2 across pointer wrap: 6 alternating-stall requests → no loss or duplication; tags come out in issue order.
- Flush with queue full and S1 occupied, while a new request is offered → next cycle out_valid 0, in_ready 1, and the offered request never appears.
- Rotate: ROL 0x8001 by 1 →
  - With SHIFT_ROTATE_EN: 0x0003, out_err 0.
  - Without: 0x8001, out_err 1.
- Async reset asserted mid-stream → all outputs take their reset values before the next clock edge.
